// File: rtl/ahb_seq_pkg.sv
// Shared types and default widths for the AHB request sequencer.
// Command structs are sized to the widest supported address and data. Parameter overrides must not exceed these widths.
package ahb_seq_pkg;

    localparam int AHB_ADDR_W   = 32;
    localparam int AHB_DATA_W   = 32;
    localparam int AHB_DEPTH    = 4;
    localparam int AHB_RESP_LAT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic                  wr;
        logic [AHB_ADDR_W-1:0] addr;
        logic [AHB_DATA_W-1:0] wdata;
    } ahb_cmd_t;

endpackage

// File: rtl/ahb_req_sequencer_if.sv
// Command, response and ahb_top-facing signals of the request sequencer.
// The slave modport is the sequencer's view. The master modport is the view of the agent driving it.
interface ahb_req_sequencer_if #(
    parameter int ADDR_W = ahb_seq_pkg::AHB_ADDR_W,
    parameter int DATA_W = ahb_seq_pkg::AHB_DATA_W,
    parameter int DEPTH  = ahb_seq_pkg::AHB_DEPTH
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] rsp_addr;
`ifdef AHB_SEQ_WRITE_ACK_EN
    logic              rsp_wr;
`endif

    logic              enable;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              wr;
    logic [DATA_W-1:0] dout;

    logic              busy;
    logic [LVL_W-1:0]  level;

`ifdef AHB_SEQ_WRITE_ACK_EN
    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, dout,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_addr, rsp_wr,
        output enable, addr, din, wr, busy, level
    );
    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, dout,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_addr, rsp_wr,
        input  enable, addr, din, wr, busy, level
    );
`else
    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, dout,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_addr,
        output enable, addr, din, wr, busy, level
    );
    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, dout,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_addr,
        input  enable, addr, din, wr, busy, level
    );
`endif

endinterface

// File: rtl/ahb_cmd_fifo.sv
// Purpose: synchronous FIFO of ahb_cmd_t with an occupancy count.
// Latency: a pushed entry is visible at the head on the next cycle. There is no bypass.
// Backpressure: full comes from registered occupancy only, so a pop never frees a slot for a same-cycle push.
module ahb_cmd_fifo
    import ahb_seq_pkg::*;
#(
    parameter int DEPTH = AHB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  ahb_cmd_t         push_dat,
    input  logic             pop_vld,
    output ahb_cmd_t         head_dat,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    ahb_cmd_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (level_q == LVL_W'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign head_dat = mem_q[rd_ptr_q];
    assign do_push  = push_vld && !full;
    assign do_pop   = pop_vld && !empty;

    // Pointers wrap naturally because DEPTH is a power of two. The extra level bit separates full from empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/ahb_req_sequencer.sv
// Purpose: queues read/write commands and issues them one at a time to ahb_top. Optional macro: AHB_SEQ_WRITE_ACK_EN.
// Latency: a write reissues every RESP_LAT+2 cycles. A read reissues every RESP_LAT+3 cycles while rsp_ready stays high.
// Backpressure: cmd_ready drops when the FIFO is full. rsp_ready low holds the FSM in RESP while the FIFO keeps filling.
module ahb_req_sequencer
    import ahb_seq_pkg::*;
#(
    parameter int DEPTH    = AHB_DEPTH,
    parameter int ADDR_W   = AHB_ADDR_W,
    parameter int DATA_W   = AHB_DATA_W,
    parameter int RESP_LAT = AHB_RESP_LAT
) (
    input  logic                hclk,
    input  logic                hreset,
    ahb_req_sequencer_if.slave  bus
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
`ifdef AHB_SEQ_WRITE_ACK_EN
    logic              rsp_wr_q, rsp_wr_d;
`endif

    ahb_cmd_t          push_dat;
    ahb_cmd_t          head_dat;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [LVL_W-1:0]  fifo_level;

    always_comb begin
        push_dat       = '0;
        push_dat.wr    = bus.cmd_wr;
        push_dat.addr  = AHB_ADDR_W'(bus.cmd_addr);
        push_dat.wdata = AHB_DATA_W'(bus.cmd_wdata);
    end

    ahb_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk      (hclk),
        .rst      (hreset),
        .push_vld (bus.cmd_valid),
        .push_dat (push_dat),
        .pop_vld  (fifo_pop),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        din_d       = din_q;
        wr_d        = wr_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_addr_d  = rsp_addr_q;
`ifdef AHB_SEQ_WRITE_ACK_EN
        rsp_wr_d    = rsp_wr_q;
`endif
        fifo_pop    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    addr_d   = head_dat.addr[ADDR_W-1:0];
                    din_d    = head_dat.wdata[DATA_W-1:0];
                    wr_d     = head_dat.wr;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(RESP_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                // A zero count lands on the cycle when dout is valid, RESP_LAT cycles after enable.
                if (cnt_q == '0) begin
                    if (!wr_q) begin
                        rsp_rdata_d = bus.dout;
                        rsp_addr_d  = addr_q;
`ifdef AHB_SEQ_WRITE_ACK_EN
                        rsp_wr_d    = 1'b0;
`endif
                        state_d     = RESP;
                    end else begin
`ifdef AHB_SEQ_WRITE_ACK_EN
                        rsp_rdata_d = '0;
                        rsp_addr_d  = addr_q;
                        rsp_wr_d    = 1'b1;
                        state_d     = RESP;
`else
                        state_d     = IDLE;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            din_q       <= '0;
            wr_q        <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_addr_q  <= '0;
`ifdef AHB_SEQ_WRITE_ACK_EN
            rsp_wr_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            wr_q        <= wr_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_addr_q  <= rsp_addr_d;
`ifdef AHB_SEQ_WRITE_ACK_EN
            rsp_wr_q    <= rsp_wr_d;
`endif
        end
    end

    assign bus.cmd_ready = !fifo_full;
    assign bus.enable    = (state_q == ISSUE);
    assign bus.addr      = addr_q;
    assign bus.din       = din_q;
    assign bus.wr        = wr_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_addr  = rsp_addr_q;
`ifdef AHB_SEQ_WRITE_ACK_EN
    assign bus.rsp_wr    = rsp_wr_q;
`endif
    assign bus.busy      = (state_q != IDLE) || !fifo_empty;
    assign bus.level     = fifo_level;

endmodule
